// File: rtl/instr_mem_fetch.sv
// Instruction memory with a program-load write port and a one-entry registered fetch response.
// Fetch addresses that are misaligned or outside the array return FAULT_WORD plus a fault code.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no response held, rsp_valid low
// ST_FULL  | one response held for decode, rsp_valid high
module instr_mem_fetch #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter int                DEPTH      = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter logic [DATA_W-1:0] FAULT_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_inst,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [1:0]        rsp_fault,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_err,
   output logic [15:0]       fetch_cnt
);

   localparam int         IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] FLT_OK       = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE    = 2'b10;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_req_ready;
   logic                w_accept;
   logic                w_consume;
   logic [ADDR_W-1:0]   w_req_idx;
   logic [ADDR_W-1:0]   w_ld_idx;
   logic [1:0]          w_req_fault;
   logic [1:0]          w_ld_fault;
   logic [DATA_W-1:0]   w_req_word;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_rsp_inst;
   logic [ADDR_W-1:0]   r_rsp_addr;
   logic [1:0]          r_rsp_fault;
   logic                r_ld_err;
   logic [15:0]         r_fetch_cnt;

   // Addresses below BASE_ADDR wrap to a huge index, but are also caught explicitly.
   function automatic logic [1:0] f_fault(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] idx);
      if (addr[1:0] != 2'b00)
         return FLT_MISALIGN;
      if ((addr < BASE_ADDR) || (idx >= ADDR_W'(DEPTH)))
         return FLT_RANGE;
      return FLT_OK;
   endfunction

   assign w_req_idx   = (req_addr - BASE_ADDR) >> 2;
   assign w_ld_idx    = (ld_addr - BASE_ADDR) >> 2;
   assign w_req_fault = f_fault(req_addr, w_req_idx);
   assign w_ld_fault  = f_fault(ld_addr, w_ld_idx);
   assign w_req_word  = (w_req_fault == FLT_OK) ? r_mem[w_req_idx[IDX_W-1:0]] : FAULT_WORD;

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = ((r_state == ST_EMPTY) || rsp_ready) && !ld_en && !flush;
      w_accept    = req_valid && w_req_ready;
      w_consume   = (r_state == ST_FULL) && rsp_ready && !flush;
      if (flush)
         w_state_nxt = ST_EMPTY;
      else if (w_accept)
         w_state_nxt = ST_FULL;
      else if (w_consume)
         w_state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   // Contents survive reset; fetches are blocked while ld_en is high so no read/write clash.
   always_ff @(posedge clk) begin
      if (ld_en && (w_ld_fault == FLT_OK))
         r_mem[w_ld_idx[IDX_W-1:0]] <= ld_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_inst  <= FAULT_WORD;
         r_rsp_addr  <= '0;
         r_rsp_fault <= FLT_OK;
      end else if (w_accept) begin
         r_rsp_inst  <= w_req_word;
         r_rsp_addr  <= req_addr;
         r_rsp_fault <= w_req_fault;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ld_err    <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         r_ld_err <= ld_en && (w_ld_fault != FLT_OK);
         if (w_consume)
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = (r_state == ST_FULL);
   assign rsp_inst  = r_rsp_inst;
   assign rsp_addr  = r_rsp_addr;
   assign rsp_fault = r_rsp_fault;
   assign ld_err    = r_ld_err;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Testbench for instr_mem_fetch: directed sequences, a fault-vector table and random traffic
// compared against a transaction-level reference model of the fetch port.
module tb_instr_mem_fetch;

   localparam int              DEPTH  = 256;
   localparam longint unsigned BASE   = 64'd0;
   localparam logic [31:0]     FAULTW = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic [31:0] rsp_addr;
   logic [1:0]  rsp_fault;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_err;
   logic [15:0] fetch_cnt;

   instr_mem_fetch #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .FAULT_WORD(FAULTW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
      .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_err(ld_err), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: memory image plus the single held response.
   logic [31:0] mem_m [DEPTH];
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_addr;
   logic [1:0]  m_fault;
   logic [15:0] m_cnt;
   logic        m_ld_err;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  fault;
      logic [31:0] inst;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] pl_addr [5];
   logic [31:0] pl_data [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] classify(input logic [31:0] a);
      longint unsigned ua;
      ua = longint'(a);
      if (ua % 4 != 0)
         return 2'b01;
      if ((ua - BASE) / 4 >= longint'(DEPTH))
         return 2'b10;
      return 2'b00;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'(a) - BASE) / 4);
   endfunction

   function automatic logic exp_ready();
      return (!m_valid || rsp_ready) && !ld_en && !flush;
   endfunction

   task automatic model_reset();
      m_valid  = 1'b0;
      m_inst   = FAULTW;
      m_addr   = '0;
      m_fault  = 2'b00;
      m_cnt    = '0;
      m_ld_err = 1'b0;
   endtask

   task automatic model_update();
      logic       acc;
      logic       con;
      logic [1:0] f;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc = req_valid && exp_ready();
      con = m_valid && rsp_ready && !flush;
      if (con)
         m_cnt = m_cnt + 16'd1;
      f = classify(ld_addr);
      m_ld_err = ld_en && (f != 2'b00);
      if (ld_en && f == 2'b00)
         mem_m[widx(ld_addr)] = ld_data;
      if (flush)
         m_valid = 1'b0;
      else if (acc) begin
         f       = classify(req_addr);
         m_valid = 1'b1;
         m_addr  = req_addr;
         m_fault = f;
         m_inst  = (f == 2'b00) ? mem_m[widx(req_addr)] : FAULTW;
      end else if (con)
         m_valid = 1'b0;
   endtask

   task automatic check_outputs();
      chk("rsp_valid", rsp_valid, m_valid);
      chk("req_ready", req_ready, exp_ready());
      chk("ld_err", ld_err, m_ld_err);
      chk("fetch_cnt", fetch_cnt, m_cnt);
      if (m_valid) begin
         chk("rsp_inst", rsp_inst, m_inst);
         chk("rsp_addr", rsp_addr, m_addr);
         chk("rsp_fault", rsp_fault, m_fault);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; req_valid = 0; req_addr = '0; rsp_ready = 0;
      ld_en = 0; ld_addr = '0; ld_data = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [31:0] a;

      vecs[0] = '{32'h0000_0064, 2'b00, 32'h8c22_0000};
      vecs[1] = '{32'h0000_0074, 2'b00, 32'h004A_3020};
      vecs[2] = '{32'h0000_0066, 2'b01, 32'h0000_0000};
      vecs[3] = '{32'h0000_0400, 2'b10, 32'h0000_0000};
      vecs[4] = '{32'h0000_0402, 2'b01, 32'h0000_0000};
      vecs[5] = '{32'h0000_03FF, 2'b01, 32'h0000_0000};
      vecs[6] = '{32'hFFFF_FFFC, 2'b10, 32'h0000_0000};
      vecs[7] = '{32'h0000_0070, 2'b00, 32'h8c25_000c};
      pl_addr[0] = 32'h64; pl_data[0] = 32'h8c22_0000;
      pl_addr[1] = 32'h68; pl_data[1] = 32'h8c23_0004;
      pl_addr[2] = 32'h6C; pl_data[2] = 32'h8c24_0008;
      pl_addr[3] = 32'h70; pl_data[3] = 32'h8c25_000c;
      pl_addr[4] = 32'h74; pl_data[4] = 32'h004A_3020;

      // Reset values
      idle_inputs();
      rst_n = 0;
      model_reset();
      #1;
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_rsp_inst", rsp_inst, FAULTW);
      chk("reset_rsp_addr", rsp_addr, 32'h0);
      chk("reset_rsp_fault", rsp_fault, 2'b00);
      chk("reset_ld_err", ld_err, 1'b0);
      chk("reset_fetch_cnt", fetch_cnt, 16'h0);
      tick(); tick();
      rst_n = 1;
      tick();

      // Fill every word so the model knows the whole image
      for (int i = 0; i < DEPTH; i++) begin
         ld_en = 1; ld_addr = 32'(i) << 2; ld_data = $urandom;
         tick();
      end

      // Program load, then immediate back-to-back fetches
      for (int i = 0; i < 5; i++) begin
         ld_en = 1; ld_addr = pl_addr[i]; ld_data = pl_data[i];
         tick();
         chk("load_ld_err", ld_err, 1'b0);
      end
      ld_en = 0;
      rsp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_addr = pl_addr[i];
         tick();
         chk("b2b_valid", rsp_valid, 1'b1);
         chk("b2b_addr", rsp_addr, pl_addr[i]);
         chk("b2b_inst", rsp_inst, pl_data[i]);
         chk("b2b_fault", rsp_fault, 2'b00);
      end
      req_valid = 0;
      tick();
      chk("b2b_cnt", fetch_cnt, 16'd5);
      chk("b2b_drained", rsp_valid, 1'b0);

      // Fault classification table
      foreach (vecs[i]) begin
         req_valid = 1; req_addr = vecs[i].addr; rsp_ready = 1;
         tick();
         req_valid = 0;
         chk("vec_valid", rsp_valid, 1'b1);
         chk("vec_fault", rsp_fault, vecs[i].fault);
         chk("vec_inst", rsp_inst, vecs[i].inst);
         chk("vec_addr", rsp_addr, vecs[i].addr);
      end
      tick();

      // Earliest fetch after a load sees the new word
      ld_en = 1; ld_addr = 32'h80; ld_data = 32'h1234_5678;
      tick();
      ld_en = 0; req_valid = 1; req_addr = 32'h80;
      tick();
      req_valid = 0;
      chk("raw_inst", rsp_inst, 32'h1234_5678);
      tick();

      // Stall: response held three cycles, then consume + accept in one cycle
      req_valid = 1; req_addr = 32'h64; rsp_ready = 1;
      tick();
      rsp_ready = 0; req_addr = 32'h68;
      #1;
      chk("stall_ready", req_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready_hold", req_ready, 1'b0);
         chk("stall_addr", rsp_addr, 32'h64);
         chk("stall_inst", rsp_inst, 32'h8c22_0000);
      end
      r = int'(fetch_cnt);
      rsp_ready = 1;
      #1;
      chk("release_ready", req_ready, 1'b1);
      tick();
      req_valid = 0;
      chk("release_addr", rsp_addr, 32'h68);
      chk("release_inst", rsp_inst, 32'h8c23_0004);
      chk("release_cnt", fetch_cnt, 16'(r + 1));
      tick();

      // Invalid loads and ld_en blocking fetch
      ld_en = 1; ld_addr = 32'h401; ld_data = 32'hDEAD_BEEF;
      req_valid = 1; req_addr = 32'h64; rsp_ready = 1;
      #1;
      chk("ld_blocks_req", req_ready, 1'b0);
      tick();
      ld_en = 0; req_valid = 0;
      chk("ld_err_pulse", ld_err, 1'b1);
      tick();
      chk("ld_err_clear", ld_err, 1'b0);
      ld_en = 1; ld_addr = 32'h66; ld_data = 32'hBAD0_BAD0;
      tick();
      ld_en = 0;
      chk("ld_err_mis", ld_err, 1'b1);
      req_valid = 1; req_addr = 32'h0;
      tick();
      req_addr = 32'h64;
      tick();
      req_valid = 0;
      chk("ld_bad_nowrite", rsp_inst, 32'h8c22_0000);
      tick();

      // Reset while FULL
      req_valid = 1; req_addr = 32'h68; rsp_ready = 0;
      tick();
      req_valid = 0;
      chk("pre_reset_full", rsp_valid, 1'b1);
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("async_reset_valid", rsp_valid, 1'b0);
      chk("async_reset_cnt", fetch_cnt, 16'h0);
      tick(); tick();
      rst_n = 1;
      tick();

      // Flush while FULL with the consumer stalled
      req_valid = 1; req_addr = 32'h6C; rsp_ready = 0;
      tick();
      chk("pre_flush_full", rsp_valid, 1'b1);
      flush = 1; req_addr = 32'h70;
      #1;
      chk("flush_blocks_req", req_ready, 1'b0);
      tick();
      flush = 0; req_valid = 0;
      chk("flush_valid", rsp_valid, 1'b0);
      chk("flush_cnt", fetch_cnt, 16'h0);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         req_valid = ($urandom_range(0, 99) < 70);
         rsp_ready = ($urandom_range(0, 99) < 70);
         flush     = ($urandom_range(0, 99) < 3);
         ld_en     = ($urandom_range(0, 99) < 6);
         r = int'($urandom_range(0, 99));
         if (r < 85)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (r < 93) a = 32'($urandom_range(0, 1100));
         else             a = $urandom;
         req_addr = a;
         r = int'($urandom_range(0, 99));
         if (r < 85) ld_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else        ld_addr = $urandom;
         ld_data = $urandom;
         tick();
      end
      idle_inputs();
      tick();
      chk("final_cnt", fetch_cnt, m_cnt);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
